// File: rtl/duty_button_ctrl.sv
// duty_button_ctrl: debounces two push-buttons into held duty_inc/duty_dec requests with auto-repeat
// Requests stay pending until the PWM enable strobe consumes them.
module duty_button_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int HOLD_DELAY_CYCLES = 64,
    parameter int REPEAT_CYCLES     = 16,
    parameter int CNT_W             = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn_up,
    input  logic btn_dn,
    output logic duty_inc,
    output logic duty_dec,
    output logic up_stable,
    output logic dn_stable,
    output logic repeat_active
);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [1:0] sync1_q, sync2_q, stable_w, prev_q, rise_w;
    state_t state_q;
    logic dir_q, inc_q, dec_q, rep_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_dn, btn_up};
            sync2_q <= sync1_q;
        end
    end

    // Bit 0 tracks the up button, bit 1 the down button.
    for (genvar i = 0; i < 2; i++) begin : g_db
        logic st_q;
        logic [CNT_W-1:0] db_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                st_q <= 1'b0;
                db_q <= '0;
            end else if (sync2_q[i] == st_q) begin
                db_q <= '0;
            end else if (db_q == DB_LAST) begin
                st_q <= ~st_q;
                db_q <= '0;
            end else begin
                db_q <= db_q + CNT_W'(1);
            end
        end
        assign stable_w[i] = st_q;
    end

    assign rise_w = stable_w & ~prev_q;

    // A request overrides a same-edge consume and clears the opposite pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            rep_q   <= 1'b0;
            prev_q  <= '0;
        end else begin
            prev_q <= stable_w;
            if (en) begin
                inc_q <= 1'b0;
                dec_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (rise_w[0] && !stable_w[1]) begin
                        inc_q   <= 1'b1;
                        dec_q   <= 1'b0;
                        dir_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= HOLD;
                    end else if (rise_w[1] && !stable_w[0]) begin
                        inc_q   <= 1'b0;
                        dec_q   <= 1'b1;
                        dir_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stable_w[dir_q] || stable_w[~dir_q]) begin
                        state_q <= IDLE;
                    end else if (cnt_q == HOLD_LAST) begin
                        inc_q   <= ~dir_q;
                        dec_q   <= dir_q;
                        cnt_q   <= '0;
                        state_q <= REPEAT;
                        rep_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!stable_w[dir_q] || stable_w[~dir_q]) begin
                        state_q <= IDLE;
                        rep_q   <= 1'b0;
                    end else if (cnt_q == REP_LAST) begin
                        inc_q <= ~dir_q;
                        dec_q <= dir_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rep_q   <= 1'b0;
                end
            endcase
        end
    end

    assign duty_inc      = inc_q;
    assign duty_dec      = dec_q;
    assign up_stable     = stable_w[0];
    assign dn_stable     = stable_w[1];
    assign repeat_active = rep_q;
endmodule

// File: tb/tb_duty_button_ctrl.sv
// tb_duty_button_ctrl: directed stimulus checked every cycle against a behavioural model of the button front-end
module tb_duty_button_ctrl;
    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 8;

    logic clk = 1'b0, rst = 1'b1, en = 1'b1, btn_up = 1'b0, btn_dn = 1'b0;
    logic duty_inc, duty_dec, up_stable, dn_stable, repeat_active;
    int tests = 0, fails = 0, cyc = 0;
    int inc_rise = 0, dec_rise = 0;
    int dec_t[$];
    logic p_inc = 1'b0, p_dec = 1'b0;

    duty_button_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_DELAY_CYCLES(H),
        .REPEAT_CYCLES(R),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .btn_up(btn_up),
        .btn_dn(btn_dn),
        .duty_inc(duty_inc),
        .duty_dec(duty_dec),
        .up_stable(up_stable),
        .dn_stable(dn_stable),
        .repeat_active(repeat_active)
    );

    always #5 clk = ~clk;

    // Model: 2-edge input delay, stable flips after D consecutive disagreeing samples,
    // requests at press age 0, H, H+R, H+2R... while the press is uncontested.
    bit [1:0] m_s1, m_s2, m_st, m_stp;
    bit [D-1:0] m_hist [2];
    bit m_inc, m_dec, m_rep, m_valid;
    int m_act = -1, m_age = 0;

    always @(posedge clk) begin
        bit [1:0] so, rise, rq;
        cyc++;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_stp = '0;
            m_hist[0] = '0; m_hist[1] = '0;
            m_inc = 0; m_dec = 0; m_rep = 0;
            m_act = -1; m_age = 0; m_valid = 1;
        end else begin
            so = m_st;
            rise = so & ~m_stp;
            rq = '0;
            if (m_act < 0) begin
                for (int b = 0; b < 2; b++)
                    if (rise[b] && !so[1-b]) begin
                        rq[b] = 1; m_act = b; m_age = 0;
                    end
            end else if (!so[m_act] || so[1-m_act]) begin
                m_act = -1;
            end else begin
                m_age++;
                if (m_age >= H && (m_age - H) % R == 0) rq[m_act] = 1;
            end
            if (rq[0]) begin m_inc = 1; m_dec = 0; end
            else if (rq[1]) begin m_inc = 0; m_dec = 1; end
            else if (en) begin m_inc = 0; m_dec = 0; end
            m_rep = (m_act >= 0) && (m_age >= H);
            for (int b = 0; b < 2; b++) begin
                m_hist[b] = {m_hist[b][D-2:0], m_s2[b]};
                if (m_hist[b] == {D{~so[b]}}) m_st[b] = ~so[b];
            end
            m_stp = so;
            m_s2 = m_s1;
            m_s1 = {btn_dn, btn_up};
        end
    end

    task automatic chk(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("duty_inc", duty_inc, m_inc);
            chk("duty_dec", duty_dec, m_dec);
            chk("up_stable", up_stable, m_st[0]);
            chk("dn_stable", dn_stable, m_st[1]);
            chk("repeat_active", repeat_active, m_rep);
            if (duty_inc && !p_inc) inc_rise++;
            if (duty_dec && !p_dec) begin
                dec_rise++;
                dec_t.push_back(cyc);
            end
            p_inc = duty_inc;
            p_dec = duty_dec;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ri, rd, base, len, r, lvl;
        repeat (2) @(negedge clk);
        chk("reset_inc", duty_inc, 1'b0);
        chk("reset_rep", repeat_active, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // clean press
        ri = inc_rise; rd = dec_rise;
        for (int k = 1; k <= 25; k++) begin
            btn_up = (k <= 10);
            @(negedge clk);
            if (k == 5) chk("t1_stable_e5", up_stable, 1'b0);
            if (k == 6) chk("t1_stable_e6", up_stable, 1'b1);
            if (k == 6) chk("t1_inc_e6", duty_inc, 1'b0);
            if (k == 7) chk("t1_inc_e7", duty_inc, 1'b1);
            if (k == 8) chk("t1_inc_e8", duty_inc, 1'b0);
        end
        chk_int("t1_inc_pulses", inc_rise - ri, 1);
        chk_int("t1_dec_pulses", dec_rise - rd, 0);

        // bounce then settle
        ri = inc_rise; len = 0; r = 0; lvl = 1;
        for (int k = 1; k <= 30; k++) begin
            btn_up = lvl[0];
            @(negedge clk);
            chk("t2_bounce_stable", up_stable, 1'b0);
            len++;
            if (len == (r % 3) + 1) begin
                len = 0; r++; lvl ^= 1;
            end
        end
        btn_up = 1'b1;
        repeat (15) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        chk_int("t2_inc_pulses", inc_rise - ri, 1);

        // hold and auto-repeat
        dec_t.delete();
        base = cyc;
        for (int k = 1; k <= 75; k++) begin
            btn_dn = (k <= 60);
            @(negedge clk);
            if (k == 26) chk("t3_rep_e26", repeat_active, 1'b0);
            if (k == 27) chk("t3_rep_e27", repeat_active, 1'b1);
            if (k == 65) chk("t3_dnst_e65", dn_stable, 1'b1);
            if (k == 66) chk("t3_dnst_e66", dn_stable, 1'b0);
            if (k == 66) chk("t3_rep_e66", repeat_active, 1'b1);
            if (k == 67) chk("t3_rep_e67", repeat_active, 1'b0);
        end
        chk_int("t3_dec_count", dec_t.size(), 6);
        if (dec_t.size() == 6) begin
            chk_int("t3_rel0", dec_t[0] - base - 7, 0);
            chk_int("t3_rel1", dec_t[1] - base - 7, 20);
            chk_int("t3_rel2", dec_t[2] - base - 7, 28);
            chk_int("t3_rel5", dec_t[5] - base - 7, 52);
        end

        // sparse enable
        for (int k = 1; k <= 60; k++) begin
            en = (k % 16 == 0);
            btn_up = (k <= 44);
            @(negedge clk);
            if (k == 7 || k == 15 || k == 27 || k == 31 || k == 35 || k == 47)
                chk("t4_pending_hi", duty_inc, 1'b1);
            if (k == 6 || k == 16 || k == 32 || k == 48 || k == 52)
                chk("t4_pending_lo", duty_inc, 1'b0);
        end
        en = 1'b1;
        repeat (5) @(negedge clk);

        // simultaneous press
        ri = inc_rise; rd = dec_rise;
        for (int k = 1; k <= 22; k++) begin
            btn_up = (k <= 12);
            btn_dn = (k <= 12);
            @(negedge clk);
            if (k == 8) chk("t5_both_up", up_stable, 1'b1);
            if (k == 8) chk("t5_both_dn", dn_stable, 1'b1);
        end
        chk_int("t5_both_inc", inc_rise - ri, 0);
        chk_int("t5_both_dec", dec_rise - rd, 0);

        // opposite press during repeat
        ri = inc_rise; rd = dec_rise;
        for (int k = 1; k <= 80; k++) begin
            btn_up = (k <= 45);
            btn_dn = (k >= 31 && k <= 65);
            @(negedge clk);
            if (k == 27) chk("t5_rep_e27", repeat_active, 1'b1);
            if (k == 35) chk("t5_inc_e35", duty_inc, 1'b1);
            if (k == 36) chk("t5_dnst_e36", dn_stable, 1'b1);
            if (k == 36) chk("t5_rep_e36", repeat_active, 1'b1);
            if (k == 37) chk("t5_rep_e37", repeat_active, 1'b0);
        end
        chk_int("t5_opp_inc", inc_rise - ri, 3);
        chk_int("t5_opp_dec", dec_rise - rd, 0);
        rd = dec_rise;
        for (int k = 1; k <= 20; k++) begin
            btn_dn = (k <= 12);
            @(negedge clk);
            if (k == 7) chk("t5_redn_e7", duty_dec, 1'b1);
        end
        chk_int("t5_redn_dec", dec_rise - rd, 1);

        // reset mid-hold with a pending request
        en = 1'b0;
        btn_up = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 24) chk("t6_pending", duty_inc, 1'b1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_inc", duty_inc, 1'b0);
        chk("t6_rst_upst", up_stable, 1'b0);
        chk("t6_rst_rep", repeat_active, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6) chk("t6_inc_e6", duty_inc, 1'b0);
            if (k == 6) chk("t6_upst_e6", up_stable, 1'b1);
            if (k == 7) chk("t6_inc_e7", duty_inc, 1'b1);
        end
        en = 1'b1;
        btn_up = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/duty_button_ctrl.md
Name: duty_button_ctrl

Overview:
Front-end stage that converts two raw, bouncy push-button inputs into the duty_inc / duty_dec request pulses consumed by the PWM generator.
- Synchronises and debounces each button.
- Issues one step request per press, plus auto-repeat while a button is held.
- Holds each request until the PWM's enable strobe consumes it, so no request is lost when the PWM is only enabled on occasional cycles.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive clk cycles a synchronised input must disagree with its stable state before that state flips (>=2)
HOLD_DELAY_CYCLES, 64, clk cycles from the first request of a press to the first auto-repeat request (>=2)
REPEAT_CYCLES, 16, clk cycles between successive auto-repeat requests (>=2)
CNT_W, 16, width of the debounce and hold/repeat counters; must hold max(parameter)-1

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
en  in  1  PWM enable strobe; a request is consumed on any clk edge with en=1
btn_up  in  1  raw asynchronous "increase" button, active-high
btn_dn  in  1  raw asynchronous "decrease" button, active-high
duty_inc  out  1  pending increase request, drives PWM duty_inc
duty_dec  out  1  pending decrease request, drives PWM duty_dec
up_stable  out  1  debounced btn_up level
dn_stable  out  1  debounced btn_dn level
repeat_active  out  1  high while the FSM is in REPEAT

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything:
  - All outputs go to 0.
  - Synchronisers, stable levels and debounce counters clear.
  - FSM goes to IDLE.
  - Pending requests are discarded.
- Reset mid-press: a button still held after reset is seen as a new press after normal debounce.
- Synchroniser: 2 flops per button.
- Debounce, per button:
  - Counter clears on any cycle where the synchronised level equals the stable level.
  - Otherwise the counter increments.
  - When it reaches DEBOUNCE_CYCLES-1 while still mismatched, the stable level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable level.
- Press latency: the first clk edge sampling btn_up=1 is edge 1. up_stable rises at edge DEBOUNCE_CYCLES+2 and duty_inc rises at edge DEBOUNCE_CYCLES+3.
- FSM (IDLE, HOLD, REPEAT), single direction tracked in a dir register:
  - IDLE: exactly one stable level rises and the other stable level is 0 -> emit request in that direction, latch dir, clear counter, go to HOLD. Both stable high -> stay in IDLE, no request.
  - HOLD: dir button released, or the opposite button becomes stable high -> IDLE. Counter reaches HOLD_DELAY_CYCLES-1 -> emit request, clear counter, go to REPEAT.
  - REPEAT: counter reaches REPEAT_CYCLES-1 -> emit request and clear counter. Release or opposite press -> IDLE with no request.
  - Return to IDLE never emits a request. A new press requires a fresh stable rising edge.
- Request timing: the second request follows the first by exactly HOLD_DELAY_CYCLES cycles; later requests are spaced REPEAT_CYCLES apart.
- Pending / consume handshake, per output:
  - At each edge, if en=1 and the output is 1, the output clears (consumed).
  - In the same edge, a new request sets its own output. A set wins over a consume of the same flag, so the output stays 1.
  - A request while its own output is already 1 and not consumed is coalesced (dropped).
  - A request in one direction clears any pending opposite-direction output, so duty_inc and duty_dec are never both 1.
- repeat_active = (state==REPEAT), registered.

Test Plan:
(DEBOUNCE_CYCLES=4, HOLD_DELAY_CYCLES=20, REPEAT_CYCLES=8, en=1 constant unless stated)
1. Clean press: btn_up high for 10 cycles -> up_stable rises at edge 6, duty_inc high for exactly 1 cycle at edge 7, no further requests, duty_dec stays 0.
2. Bounce: btn_up toggles with 1–3 cycle pulses for 30 cycles, then settles high -> up_stable never rises during bounce, exactly one duty_inc pulse after settling.
3. Hold/auto-repeat: btn_dn held 60 cycles -> duty_dec pulses at relative cycles 0, 20, 28, 36, 44, 52; repeat_active=1 from cycle 20 until 1 cycle after dn_stable falls.
4. Sparse en: en=1 only every 16th cycle, btn_up press -> duty_inc rises at edge 7 and stays high until the first en=1 edge, then clears; a repeat request arriving while still pending is coalesced.
5. Simultaneous and opposite presses: both buttons pressed together -> no requests. Press up, then press dn while up is held in REPEAT -> FSM to IDLE, no dn request until up releases and dn rises again.
6. Reset mid-hold: rst for 1 cycle at cycle 25 of a held btn_up -> all outputs 0 next cycle, pending duty_inc cleared, new duty_inc at edge 7 after reset release.
